// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 widths, GF(2^8) xtime and byte-position helper
package aes_pkg;
  localparam int STATE_W = 128;
  localparam logic [7:0] AES_POLY = 8'h1B;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic int byte_lsb(input int row, input int col);
    return STATE_W - 8 - 8 * (4 * col + row);
  endfunction
endpackage

// File: rtl/mix_column.sv
// mix_column: combinational AES MixColumns on one 32-bit column, row 0 in the top byte
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  logic [7:0] w_s [4];
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_s[r] = i_col[31-8*r -: 8];
    assign o_col[31-8*r -: 8] = xtime(w_s[r]) ^ xtime(w_s[(r+1)%4]) ^ w_s[(r+1)%4]
                              ^ w_s[(r+2)%4] ^ w_s[(r+3)%4];
  end
endmodule

// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows/MixColumns/AddRoundKey into a valid/ready output register; AES_ROUND_TAIL_SKID_EN adds a skid register and registered in_ready
module aes_round_tail
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_last
);
  logic [STATE_W-1:0] w_sr, w_mc, w_res;
  logic               w_acc;
  logic               r_out_valid, r_out_last;
  logic [STATE_W-1:0] r_out_state;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[byte_lsb(r, c) +: 8] = in_state[byte_lsb(r, (c + r) % 4) +: 8];
    end
    mix_column u_mix (
      .i_col(w_sr[byte_lsb(3, c) +: 32]),
      .o_col(w_mc[byte_lsb(3, c) +: 32])
    );
  end
  assign w_res     = (in_last ? w_sr : w_mc) ^ in_key;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign out_last  = r_out_last;
`ifdef AES_ROUND_TAIL_SKID_EN
  logic               r_skid_valid, r_skid_last;
  logic [STATE_W-1:0] r_skid_state;
  logic               w_load;
  assign in_ready = !r_skid_valid;
  assign w_load   = !r_out_valid || out_ready;
  // A full skid blocks the input, so w_acc and a skid hand-over never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_state  <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_state <= '0;
      r_skid_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= r_skid_valid || w_acc;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) begin
        r_out_state <= r_skid_state;
        r_out_last  <= r_skid_last;
      end else if (w_acc) begin
        r_out_state <= w_res;
        r_out_last  <= in_last;
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_state <= w_res;
      r_skid_last  <= in_last;
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_out_last  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_state <= w_res;
      r_out_last  <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_aes_round_tail.sv
// tb_aes_round_tail: directed scoreboard bench for aes_round_tail (either AES_ROUND_TAIL_SKID_EN build)
module tb_aes_round_tail;
`ifdef AES_ROUND_TAIL_SKID_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [127:0] in_state = '0, in_key = '0;
  logic         in_ready, out_valid, out_last;
  logic [127:0] out_state;
  int           n_checks = 0, n_err = 0, n_acc = 0, n_pop = 0;
  logic [128:0] q [$];
  aes_round_tail dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_last(out_last)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic l);
    logic [7:0]   a [4][4], b [4][4], m [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) a[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r][c] = a[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = l ? b[r][c] : gm(8'h02, b[r][c]) ^ gm(8'h03, b[(r+1)%4][c]) ^ b[(r+2)%4][c] ^ b[(r+3)%4][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = m[r][c];
    return res ^ k;
  endfunction
  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
    in_valid = 1'b1;
    in_state = s;
    in_key   = k;
    in_last  = l;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) chk("sb_unexpected", {out_last, out_state}, 129'bx);
        else chk("sb_result", {out_last, out_state}, q.pop_front());
      end
      if (in_valid && in_ready) begin
        n_acc++;
        q.push_back({in_last, ref_round(in_state, in_key, in_last)});
      end
    end
  end
  initial begin
    logic [127:0] held;
    int           acc0, pop0, t;
    repeat (2) cyc();
    chk("rst_out_valid", 129'(out_valid), 129'(0));
    chk("rst_out_state", 129'(out_state), 129'(0));
    chk("rst_out_last", 129'(out_last), 129'(0));
    chk("rst_in_ready", 129'(in_ready), 129'(1));
    rst_n = 1'b1;
    cyc();
    send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("r1_valid", 129'(out_valid), 129'(1));
    chk("r1_state", 129'(out_state), 129'(128'ha49c7ff2689f352b6b5bea43026a5049));
    chk("r1_last", 129'(out_last), 129'(0));
    cyc();
    send(128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("r10_state", 129'(out_state), 129'(128'h3925841d02dc09fbdc118597196a0b32));
    chk("r10_last", 129'(out_last), 129'(1));
    cyc();
    send('0, '0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("zero_valid", 129'(out_valid), 129'(1));
    chk("zero_state", 129'(out_state), 129'(0));
    cyc();
    out_ready = 1'b0;
    send(rnd128(), rnd128(), 1'b0);
    cyc();
    held = out_state;
    acc0 = n_acc;
    send(rnd128(), rnd128(), 1'b1);
    repeat (5) begin
      cyc();
      chk("stall_hold_state", 129'(out_state), 129'(held));
      chk("stall_hold_valid", 129'(out_valid), 129'(1));
      if (n_acc != acc0) in_valid = 1'b0;
    end
    chk("stall_extra_accepts", 129'(n_acc - acc0), 129'(EXTRA));
    chk("stall_in_ready", 129'(in_ready), 129'(0));
    pop0 = n_pop;
    out_ready = 1'b1;
    t = 0;
    while ((in_valid || q.size() != 0) && t < 20) begin
      cyc();
      t++;
      if (n_acc - acc0 == 1) in_valid = 1'b0;
    end
    chk("stall_drain_timeout", 129'(t < 20), 129'(1));
    chk("stall_drain_count", 129'(n_pop - pop0), 129'(2));
    pop0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      send(rnd128(), rnd128(), 1'(i % 3 == 2));
      cyc();
      chk("stream_valid", 129'(out_valid), 129'(1));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_count", 129'(n_pop - pop0), 129'(8));
    chk("stream_idle", 129'(out_valid), 129'(0));
    out_ready = 1'b0;
    send(rnd128(), rnd128(), 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("mid_rst_pre_valid", 129'(out_valid), 129'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 129'(out_valid), 129'(0));
    chk("mid_rst_state", 129'(out_state), 129'(0));
    chk("mid_rst_last", 129'(out_last), 129'(0));
    q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 129'(in_ready), 129'(1));
    chk("post_rst_valid", 129'(out_valid), 129'(0));
    out_ready = 1'b1;
    cyc();
    chk("sb_empty", 129'(q.size()), 129'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
